// File: rtl/fp_add_pkg.sv
// Shared FP-adder definitions: format widths, exponent encodings used by
// fp_add_unpack and spc_case, field-slice helpers and the unpacked-operand struct.
package fp_add_pkg;

  localparam int FP_E_WIDTH = 8;
  localparam int FP_M_WIDTH = 23;
  localparam int FP_D_WIDTH = 5;
  localparam int FP_W       = FP_E_WIDTH + FP_M_WIDTH + 1;

  localparam logic [FP_E_WIDTH-1:0] FP_BIAS          = FP_E_WIDTH'(1 << (FP_E_WIDTH - 1));
  localparam logic [FP_E_WIDTH-1:0] FP_EXP_INF_NAN   = FP_BIAS;
  localparam logic [FP_E_WIDTH-1:0] FP_EXP_ZERO      = FP_BIAS + FP_E_WIDTH'(1);
  localparam logic [FP_E_WIDTH-1:0] FP_EXP_ORG_ZERO  = {FP_E_WIDTH{1'b0}};
  localparam logic [FP_E_WIDTH-1:0] FP_EXP_ORG_ONES  = {FP_E_WIDTH{1'b1}};
  localparam logic [FP_E_WIDTH-1:0] FP_EXP_EFF_MIN   = FP_E_WIDTH'(1);

  typedef logic [FP_W-1:0] fp_word_t;

  typedef struct packed {
    logic                  sign;
    logic [FP_E_WIDTH-1:0] exp_org;
    logic [FP_E_WIDTH-1:0] exp_unb;
    logic [FP_E_WIDTH-1:0] exp_eff;
    logic [FP_M_WIDTH-1:0] mnt;
    logic [FP_M_WIDTH:0]   sig;
  } fp_unpacked_t;

  function automatic logic fp_sign(input fp_word_t w);
    return w[FP_W-1];
  endfunction

  function automatic logic [FP_E_WIDTH-1:0] fp_exp(input fp_word_t w);
    return w[FP_W-2 -: FP_E_WIDTH];
  endfunction

  function automatic logic [FP_M_WIDTH-1:0] fp_mnt(input fp_word_t w);
    return w[FP_M_WIDTH-1:0];
  endfunction

  // Wraps modulo 2^E so all-ones lands on BIAS and zero on BIAS+1.
  function automatic logic [FP_E_WIDTH-1:0] fp_unbias(input logic [FP_E_WIDTH-1:0] e);
    return e - (FP_BIAS - FP_E_WIDTH'(1));
  endfunction

endpackage

// File: rtl/fp_field_split.sv
// Combinational splitter for one packed operand into sign/exponent/mantissa views.
// Honours FP_UNPACK_DAZ_EN (subnormals flushed to signed zero when defined).
module fp_field_split
  import fp_add_pkg::*;
(
  input  fp_word_t     word_i,
  output fp_unpacked_t fields_o
);

  // Field extraction, hidden bit and effective exponent.
  always_comb begin
    fields_o         = '0;
    fields_o.sign    = fp_sign(word_i);
    fields_o.exp_org = fp_exp(word_i);
    fields_o.exp_unb = fp_unbias(fields_o.exp_org);
    fields_o.mnt     = fp_mnt(word_i);
    if (fields_o.exp_org != FP_EXP_ORG_ZERO) begin
      fields_o.exp_eff = fields_o.exp_org;
      fields_o.sig     = {1'b1, fields_o.mnt};
    end else begin
`ifdef FP_UNPACK_DAZ_EN
      fields_o.mnt     = {FP_M_WIDTH{1'b0}};
`endif
      fields_o.exp_eff = FP_EXP_EFF_MIN;
      fields_o.sig     = {1'b0, fields_o.mnt};
    end
  end

endmodule

// File: rtl/fp_add_unpack.sv
// FP adder operand intake: two-stage valid/ready pipeline that unpacks both operands,
// orders them by magnitude and saturates the exponent difference. Option: FP_UNPACK_DAZ_EN.
module fp_add_unpack
  import fp_add_pkg::*;
#(
  parameter int E_WIDTH = FP_E_WIDTH,
  parameter int M_WIDTH = FP_M_WIDTH,
  parameter int D_WIDTH = FP_D_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [E_WIDTH+M_WIDTH:0] op_A,
  input  logic [E_WIDTH+M_WIDTH:0] op_B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sign_A,
  output logic                     sign_B,
  output logic [E_WIDTH-1:0]       exp_A,
  output logic [E_WIDTH-1:0]       exp_B,
  output logic [E_WIDTH-1:0]       exp_A_org,
  output logic [E_WIDTH-1:0]       exp_B_org,
  output logic [M_WIDTH-1:0]       mnt_A,
  output logic [M_WIDTH-1:0]       mnt_B,
  output logic [M_WIDTH:0]         sig_big,
  output logic [M_WIDTH:0]         sig_small,
  output logic [E_WIDTH-1:0]       exp_big,
  output logic [D_WIDTH-1:0]       exp_diff,
  output logic                     swapped,
  output logic                     eff_sub
);

  localparam logic [E_WIDTH-1:0] DIFF_MAX = E_WIDTH'((1 << D_WIDTH) - 1);

  typedef struct packed {
    logic               sign_a;
    logic               sign_b;
    logic [E_WIDTH-1:0] exp_a;
    logic [E_WIDTH-1:0] exp_b;
    logic [E_WIDTH-1:0] exp_a_org;
    logic [E_WIDTH-1:0] exp_b_org;
    logic [M_WIDTH-1:0] mnt_a;
    logic [M_WIDTH-1:0] mnt_b;
    logic [M_WIDTH:0]   sig_big;
    logic [M_WIDTH:0]   sig_small;
    logic [E_WIDTH-1:0] exp_big;
    logic [D_WIDTH-1:0] exp_diff;
    logic               swapped;
    logic               eff_sub;
  } res_t;

  logic                     s1_valid_q, s1_valid_d;
  logic [E_WIDTH+M_WIDTH:0] a_q, a_d, b_q, b_d;
  logic                     out_valid_q, out_valid_d;
  res_t                     res_q, res_d, res_s;
  logic                     s1_adv_s, s2_adv_s;

  fp_unpacked_t             fa_s, fb_s, big_s, small_s;
  logic [E_WIDTH-1:0]       diff_full_s;

  assign s2_adv_s = !out_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  assign in_ready = s1_adv_s;

  fp_field_split u_split_a (.word_i(a_q), .fields_o(fa_s));
  fp_field_split u_split_b (.word_i(b_q), .fields_o(fb_s));

  // Stage-2 datapath: magnitude ordering and saturated exponent difference.
  always_comb begin
    res_s           = '0;
    res_s.sign_a    = fa_s.sign;
    res_s.sign_b    = fb_s.sign;
    res_s.exp_a     = fa_s.exp_unb;
    res_s.exp_b     = fb_s.exp_unb;
    res_s.exp_a_org = fa_s.exp_org;
    res_s.exp_b_org = fb_s.exp_org;
    res_s.mnt_a     = fa_s.mnt;
    res_s.mnt_b     = fb_s.mnt;
    res_s.swapped   = {fb_s.exp_org, fb_s.mnt} > {fa_s.exp_org, fa_s.mnt};
    res_s.eff_sub   = fa_s.sign ^ fb_s.sign;
    if (res_s.swapped) begin
      big_s   = fb_s;
      small_s = fa_s;
    end else begin
      big_s   = fa_s;
      small_s = fb_s;
    end
    res_s.sig_big   = big_s.sig;
    res_s.sig_small = small_s.sig;
    res_s.exp_big   = big_s.exp_eff;
    diff_full_s     = big_s.exp_eff - small_s.exp_eff;
    if (diff_full_s > DIFF_MAX) begin
      res_s.exp_diff = {D_WIDTH{1'b1}};
    end else begin
      res_s.exp_diff = D_WIDTH'(diff_full_s);
    end
  end

  // Pipeline next-state; data only loads on a real transfer so bubbles leave it intact.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = op_A;
        b_d = op_B;
      end else begin
        a_d = a_q;
        b_d = b_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = res_s;
      end else begin
        res_d = res_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign_A    = res_q.sign_a;
  assign sign_B    = res_q.sign_b;
  assign exp_A     = res_q.exp_a;
  assign exp_B     = res_q.exp_b;
  assign exp_A_org = res_q.exp_a_org;
  assign exp_B_org = res_q.exp_b_org;
  assign mnt_A     = res_q.mnt_a;
  assign mnt_B     = res_q.mnt_b;
  assign sig_big   = res_q.sig_big;
  assign sig_small = res_q.sig_small;
  assign exp_big   = res_q.exp_big;
  assign exp_diff  = res_q.exp_diff;
  assign swapped   = res_q.swapped;
  assign eff_sub   = res_q.eff_sub;

endmodule

// File: tb/tb_fp_add_unpack.sv
// Scoreboard bench for fp_add_unpack: directed plan vectors plus random operand pairs
// under random backpressure, compared against an arithmetic reference model.
module tb_fp_add_unpack;

  typedef struct packed {
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [7:0]  exp_a_org;
    logic [7:0]  exp_b_org;
    logic [22:0] mnt_a;
    logic [22:0] mnt_b;
    logic [23:0] sig_big;
    logic [23:0] sig_small;
    logic [7:0]  exp_big;
    logic [4:0]  exp_diff;
    logic        swapped;
    logic        eff_sub;
  } res_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_A, op_B;
  logic        sign_A, sign_B, swapped, eff_sub;
  logic [7:0]  exp_A, exp_B, exp_A_org, exp_B_org, exp_big;
  logic [22:0] mnt_A, mnt_B;
  logic [23:0] sig_big, sig_small;
  logic [4:0]  exp_diff;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   mode   = 1;
  res_t sb_q[$];
  res_t prev_r;
  logic prev_stall = 1'b0;

  fp_add_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_A(op_A), .op_B(op_B), .out_valid(out_valid), .out_ready(out_ready),
    .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
    .exp_A_org(exp_A_org), .exp_B_org(exp_B_org), .mnt_A(mnt_A), .mnt_B(mnt_B),
    .sig_big(sig_big), .sig_small(sig_small), .exp_big(exp_big),
    .exp_diff(exp_diff), .swapped(swapped), .eff_sub(eff_sub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    int     ea, eb, ma, mb, effa, effb, siga, sigb, d;
    longint maga, magb;
    ea = int'((a / 32'd8388608) % 32'd256);
    eb = int'((b / 32'd8388608) % 32'd256);
    ma = int'(a % 32'd8388608);
    mb = int'(b % 32'd8388608);
`ifdef FP_UNPACK_DAZ_EN
    if (ea == 0) ma = 0;
    if (eb == 0) mb = 0;
`endif
    effa = (ea == 0) ? 1 : ea;
    effb = (eb == 0) ? 1 : eb;
    siga = (ea == 0) ? ma : ma + 8388608;
    sigb = (eb == 0) ? mb : mb + 8388608;
    maga = longint'(ea) * 8388608 + ma;
    magb = longint'(eb) * 8388608 + mb;
    r.sign_a    = (a >= 32'h80000000);
    r.sign_b    = (b >= 32'h80000000);
    r.exp_a     = 8'((ea - 127 + 256) % 256);
    r.exp_b     = 8'((eb - 127 + 256) % 256);
    r.exp_a_org = 8'(ea);
    r.exp_b_org = 8'(eb);
    r.mnt_a     = 23'(ma);
    r.mnt_b     = 23'(mb);
    r.swapped   = (magb > maga);
    r.eff_sub   = (r.sign_a != r.sign_b);
    if (r.swapped) begin
      r.sig_big = 24'(sigb); r.sig_small = 24'(siga); r.exp_big = 8'(effb); d = effb - effa;
    end else begin
      r.sig_big = 24'(siga); r.sig_small = 24'(sigb); r.exp_big = 8'(effa); d = effa - effb;
    end
    r.exp_diff = 5'((d > 31) ? 31 : d);
    return r;
  endfunction

  function automatic res_t sample();
    return {sign_A, sign_B, exp_A, exp_B, exp_A_org, exp_B_org, mnt_A, mnt_B,
            sig_big, sig_small, exp_big, exp_diff, swapped, eff_sub};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Backpressure generator: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    if (mode == 0)      out_ready = 1'b0;
    else if (mode == 1) out_ready = 1'b1;
    else                out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: output hold check while stalled, scoreboard pop on each transfer.
  always @(negedge clk) begin
    res_t cur, exp_r;
    if (!rst && out_valid) begin
      cur = sample();
      if (prev_stall) begin
        n_vec++;
        if (cur !== prev_r) begin
          n_miss++;
          $display("FAIL hold: got %h, expected %h", cur, prev_r);
        end
      end
      if (out_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_output: got %h, expected no output", cur);
        end else begin
          exp_r = sb_q.pop_front();
          if (cur !== exp_r) begin
            n_miss++;
            $display("FAIL data: got %h, expected %h", cur, exp_r);
          end
        end
      end
      prev_r = cur;
    end
    prev_stall = !rst && out_valid && !out_ready;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int   n    = 0;
    logic done = 1'b0;
    op_A = a; op_B = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(ref_model(a, b));
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        n_vec++; n_miss++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    int          acc, n;
    rst = 1'b1; in_valid = 1'b0; op_A = 32'h0; op_B = 32'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    n_vec++;
    if (sample() !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %h, expected 0", sample());
    end
    @(posedge clk); #1;

    send(32'h40400000, 32'h3F800000);
    send(32'h3F800000, 32'hC1200000);
    send(32'h7F800000, 32'h00000000);
    send(32'h7E800000, 32'h00800000);
    send(32'h3F800000, 32'h3F800000);
    send(32'h00000001, 32'h80000003);

    // Backpressure: stall while offering four pairs; only two fit in the pipe.
    repeat (3) @(posedge clk); #1;
    mode = 0;
    @(posedge clk); #1;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h41000000 + 32'(acc); b = 32'h40000000 + 32'(acc);
      op_A = a; op_B = b;
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(ref_model(a, b));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    mode = 1;
    for (int i = acc; i < 4; i++) send(32'h41000000 + 32'(i), 32'h40000000 + 32'(i));

    // Reset with two pairs in flight.
    repeat (4) @(posedge clk); #1;
    mode = 0;
    @(posedge clk); #1;
    send(32'h40A00000, 32'h40800000);
    send(32'h40C00000, 32'h40E00000);
    #1 rst = 1'b1;
    #1 chk("rst_flush_out_valid", {31'h0, out_valid}, 32'h0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; mode = 1;
    send(32'h3F800000, 32'h00000001);

    // Random operands with random backpressure.
    mode = 2;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 6))
        0: b = a;
        1: b[30:23] = a[30:23];
        2: a[30:23] = 8'h00;
        3: b[30:23] = 8'hFF;
        4: begin a[30:23] = 8'h00; b[30:23] = 8'h00; end
        5: b[30:23] = a[30:23] + 8'($urandom_range(0, 40));
        default: ;
      endcase
      send(a, b);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    mode = 1;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
